// File: rtl/tetris_piece_ctrl.sv
// Falling 2x2 piece controller for an 8x8 Tetris board with gravity, moves and row clearing.
// Defining TETRIS_HARD_DROP_EN adds the hard_drop input and its drop-to-floor behaviour.
module tetris_piece_ctrl #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            move_left,
   input  logic            move_right,
`ifdef TETRIS_HARD_DROP_EN
   input  logic            hard_drop,
`endif
   output logic [5:0]      blk_1,
   output logic [5:0]      blk_2,
   output logic [5:0]      blk_3,
   output logic [5:0]      blk_4,
   output logic [7:0][7:0] fallenBlocks,
   output logic            gameState,
   output logic [7:0]      score,
   output logic            busy
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StSpawn = 3'd1;
   localparam logic [2:0] StFall  = 3'd2;
   localparam logic [2:0] StLock  = 3'd3;
   localparam logic [2:0] StClear = 3'd4;
   localparam logic [2:0] StOver  = 3'd5;

   logic [2:0]      state_q, state_d;
   logic [2:0]      px_q, px_d, py_q, py_d;
   logic [2:0]      row_q, row_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0][7:0] board_q, board_d;
   logic [7:0]      score_q, score_d;
   logic            pend_l_q, pend_l_d, pend_r_q, pend_r_d, pend_t_q, pend_t_d;
   logic            in_game, tick, req_l, req_r, req_t;
   logic [3:0]      x4, y4;
`ifdef TETRIS_HARD_DROP_EN
   logic            pend_h_q, pend_h_d, req_h;
`endif

   // True when a 2x2 piece with top-left (x,y) lies on the board and overlaps no settled cell.
   function automatic logic fits(input logic [7:0][7:0] b, input logic [3:0] x,
                                 input logic [3:0] y);
      logic [3:0] x1, y1;
      x1 = x + 4'd1;
      y1 = y + 4'd1;
      if (x > 4'd6 || y > 4'd6) return 1'b0;
      return !(b[y[2:0]][~x[2:0]] || b[y[2:0]][~x1[2:0]] ||
               b[y1[2:0]][~x[2:0]] || b[y1[2:0]][~x1[2:0]]);
   endfunction

   always_comb begin
      state_d  = state_q;
      px_d     = px_q;
      py_d     = py_q;
      row_d    = row_q;
      cnt_d    = '0;
      board_d  = board_q;
      score_d  = score_q;
      x4       = {1'b0, px_q};
      y4       = {1'b0, py_q};
      in_game  = (state_q != StIdle) && (state_q != StOver);
      tick     = (state_q == StFall) && (cnt_q == CntW'(TICK_DIV - 1));
      req_l    = in_game && (pend_l_q || move_left);
      req_r    = in_game && (pend_r_q || move_right);
      req_t    = in_game && (pend_t_q || tick);
      pend_l_d = req_l;
      pend_r_d = req_r;
      pend_t_d = req_t;
`ifdef TETRIS_HARD_DROP_EN
      req_h    = in_game && (pend_h_q || hard_drop);
      pend_h_d = req_h;
`endif

      unique case (state_q)
         StIdle, StOver: begin
            if (start) begin
               board_d = '0;
               score_d = '0;
               state_d = StSpawn;
            end
         end
         StSpawn: begin
            if (!fits(board_q, 4'd3, 4'd0)) begin
               state_d = StOver;
            end else begin
               px_d    = 3'd3;
               py_d    = 3'd0;
               state_d = StFall;
            end
         end
         StFall: begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
`ifdef TETRIS_HARD_DROP_EN
            // Hard drop stays pending until the piece can no longer descend.
            if (req_h) begin
               if (fits(board_q, x4, y4 + 4'd1)) begin
                  py_d = py_q + 3'd1;
               end else begin
                  pend_h_d = 1'b0;
                  state_d  = StLock;
               end
            end else
`endif
            if (req_t) begin
               pend_t_d = 1'b0;
               if (fits(board_q, x4, y4 + 4'd1)) py_d = py_q + 3'd1;
               else state_d = StLock;
            end else if (req_l) begin
               pend_l_d = 1'b0;
               if (fits(board_q, x4 - 4'd1, y4)) px_d = px_q - 3'd1;
            end else if (req_r) begin
               pend_r_d = 1'b0;
               if (fits(board_q, x4 + 4'd1, y4)) px_d = px_q + 3'd1;
            end
         end
         StLock: begin
            board_d[py_q][~px_q]                 = 1'b1;
            board_d[py_q][~(px_q + 3'd1)]        = 1'b1;
            board_d[py_q + 3'd1][~px_q]          = 1'b1;
            board_d[py_q + 3'd1][~(px_q + 3'd1)] = 1'b1;
            row_d   = 3'd7;
            state_d = StClear;
         end
         StClear: begin
            if (board_q[row_q] == 8'hFF) begin
               for (int r = 1; r < 8; r++) begin
                  if (3'(r) <= row_q) board_d[3'(r)] = board_q[3'(r - 1)];
               end
               board_d[0] = '0;
               if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end else if (row_q == 3'd0) begin
               state_d = StSpawn;
            end else begin
               row_d = row_q - 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d == StIdle || state_d == StOver || state_d == StSpawn) begin
         pend_l_d = 1'b0;
         pend_r_d = 1'b0;
         pend_t_d = 1'b0;
`ifdef TETRIS_HARD_DROP_EN
         pend_h_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         px_q     <= 3'd3;
         py_q     <= 3'd0;
         row_q    <= 3'd7;
         cnt_q    <= '0;
         board_q  <= '0;
         score_q  <= '0;
         pend_l_q <= 1'b0;
         pend_r_q <= 1'b0;
         pend_t_q <= 1'b0;
`ifdef TETRIS_HARD_DROP_EN
         pend_h_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         px_q     <= px_d;
         py_q     <= py_d;
         row_q    <= row_d;
         cnt_q    <= cnt_d;
         board_q  <= board_d;
         score_q  <= score_d;
         pend_l_q <= pend_l_d;
         pend_r_q <= pend_r_d;
         pend_t_q <= pend_t_d;
`ifdef TETRIS_HARD_DROP_EN
         pend_h_q <= pend_h_d;
`endif
      end
   end

   assign blk_1        = {py_q, px_q};
   assign blk_2        = {py_q, px_q + 3'd1};
   assign blk_3        = {py_q + 3'd1, px_q};
   assign blk_4        = {py_q + 3'd1, px_q + 3'd1};
   assign fallenBlocks = board_q;
   assign score        = score_q;
   assign gameState    = (state_q == StSpawn) || (state_q == StFall) ||
                         (state_q == StLock) || (state_q == StClear);
   assign busy         = (state_q == StLock) || (state_q == StClear);

endmodule

// File: tb/tb_tetris_piece_ctrl.sv
// Directed bench for tetris_piece_ctrl with TICK_DIV=4: vector table plus multi-cycle sequences.
module tb_tetris_piece_ctrl;

   logic            clk = 1'b0;
   logic            reset, start, move_left, move_right;
`ifdef TETRIS_HARD_DROP_EN
   logic            hard_drop;
`endif
   logic [5:0]      blk_1, blk_2, blk_3, blk_4;
   logic [7:0][7:0] fallenBlocks;
   logic            gameState, busy;
   logic [7:0]      score;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic st;
      logic ml;
      logic mr;
      int   b;
      logic gs;
      logic bz;
   } vec_t;

   vec_t tbl[21];

   always #5 clk = ~clk;

   tetris_piece_ctrl #(.TICK_DIV(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .move_left    (move_left),
      .move_right   (move_right),
`ifdef TETRIS_HARD_DROP_EN
      .hard_drop    (hard_drop),
`endif
      .blk_1        (blk_1),
      .blk_2        (blk_2),
      .blk_3        (blk_3),
      .blk_4        (blk_4),
      .fallenBlocks (fallenBlocks),
      .gameState    (gameState),
      .score        (score),
      .busy         (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected blk_1..blk_4 for a square whose top-left cell is b.
   function automatic logic [23:0] sq(input int b);
      return {6'(b), 6'(b + 1), 6'(b + 8), 6'(b + 9)};
   endfunction

   // Shift the freshly spawned piece by dx columns, then let it fall and run through LOCK/CLEAR.
   task automatic play_piece(input int dx, output logic [5:0] lock_b, output int busy_n);
      int n;
      for (int i = 0; i < ((dx < 0) ? -dx : dx); i++) begin
         if (dx < 0) move_left = 1'b1;
         else move_right = 1'b1;
         step();
         move_left  = 1'b0;
         move_right = 1'b0;
         step();
      end
      n = 0;
      while (!busy && n < 200) begin
         step();
         n++;
      end
      check("reach_lock", busy, 1);
      lock_b = blk_1;
      busy_n = 0;
      while (busy && busy_n < 50) begin
         busy_n++;
         step();
      end
      step();
   endtask

   initial begin
      logic [5:0] lb;
      int         bn;
      int         n;

      tbl[0]  = '{1'b1, 1'b0, 1'b0,  3, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 11, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0,  9, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0,  8, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 17, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 18, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 26, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 27, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 27, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 27, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 35, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 36, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 36, 1'b1, 1'b0};
      tbl[20] = '{1'b1, 1'b0, 1'b0, 36, 1'b1, 1'b0};

      reset      = 1'b1;
      start      = 1'b0;
      move_left  = 1'b0;
      move_right = 1'b0;
`ifdef TETRIS_HARD_DROP_EN
      hard_drop  = 1'b0;
`endif
      step();
      step();
      check("rst_blk", {blk_1, blk_2, blk_3, blk_4}, sq(3));
      check("rst_board", fallenBlocks, 64'h0);
      check("rst_status", {score, gameState, busy}, 10'h0);
      reset = 1'b0;

      // Start, gravity, tick-vs-left priority, wall bump, absorption, start ignored in FALL.
      foreach (tbl[i]) begin
         start      = tbl[i].st;
         move_left  = tbl[i].ml;
         move_right = tbl[i].mr;
         step();
         start      = 1'b0;
         move_left  = 1'b0;
         move_right = 1'b0;
         check($sformatf("vec%0d", i), {blk_1, blk_2, blk_3, blk_4, gameState, busy},
               {sq(tbl[i].b), tbl[i].gs, tbl[i].bz});
      end
      check("vec_board", {fallenBlocks, score}, 72'h0);

      // Build rows 6,7 = FC, then complete them with a piece at x=6.
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_fall_gs", gameState, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      play_piece(-3, lb, bn);
      check("p1_lock", lb, 48);
      check("p1_busy", bn, 9);
      play_piece(-1, lb, bn);
      check("p2_lock", lb, 50);
      play_piece(1, lb, bn);
      check("p3_lock", lb, 52);
      check("rows67", fallenBlocks, 64'hFCFC_0000_0000_0000);
      check("score0", score, 0);
      play_piece(3, lb, bn);
      check("p4_lock", lb, 54);
      check("p4_busy", bn, 11);
      check("clr_board", fallenBlocks, 64'h0);
      check("clr_score", score, 2);
      check("clr_respawn", {blk_1, blk_2, blk_3, blk_4, gameState, busy}, {sq(3), 2'b10});

      // Stack at the spawn column until spawn is blocked.
      play_piece(0, lb, bn);
      check("s1_lock", lb, 51);
      play_piece(0, lb, bn);
      check("s2_lock", lb, 35);
      play_piece(0, lb, bn);
      check("s3_lock", lb, 19);
      play_piece(0, lb, bn);
      check("s4_lock", lb, 3);
      check("s4_busy", bn, 9);
      check("over_status", {gameState, busy, score}, {2'b00, 8'd2});
      check("over_board", fallenBlocks, 64'h1818_1818_1818_1818);
      move_left = 1'b1;
      step();
      move_left  = 1'b0;
      move_right = 1'b1;
      step();
      move_right = 1'b0;
      step();
      check("over_hold", {blk_1, blk_2, blk_3, blk_4, gameState}, {sq(3), 1'b0});
      check("over_hold_board", fallenBlocks, 64'h1818_1818_1818_1818);
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart", {fallenBlocks, score, gameState}, {72'h0, 1'b1});
      for (int i = 0; i < 5; i++) step();
      check("restart_fall", {blk_1, blk_2, blk_3, blk_4}, sq(11));

      // Reset in the middle of CLEAR, together with start and a move request.
      n = 0;
      while (!busy && n < 200) begin
         step();
         n++;
      end
      check("reach_lock2", busy, 1);
      step();
      reset      = 1'b1;
      start      = 1'b1;
      move_left  = 1'b1;
      step();
      reset      = 1'b0;
      start      = 1'b0;
      move_left  = 1'b0;
      check("rclr_blk", {blk_1, blk_2, blk_3, blk_4}, sq(3));
      check("rclr_board", fallenBlocks, 64'h0);
      check("rclr_status", {score, gameState, busy}, 10'h0);
      step();
      check("rclr_idle", {gameState, busy}, 2'b00);

`ifdef TETRIS_HARD_DROP_EN
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      hard_drop = 1'b1;
      step();
      hard_drop = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("hd_pos", {blk_1, blk_2, blk_3, blk_4, busy}, {sq(51), 1'b0});
      step();
      check("hd_lock", {blk_1, busy}, {6'd51, 1'b1});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tetris_piece_ctrl.md
TETRIS_PIECE_CTRL -- requirements
Module: tetris_piece_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per gravity step (min 4).
REQ-002 SHALL have port clk  input  1  rising-edge system clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse; begins a game from IDLE or OVER.
REQ-005 SHALL have ports move_left, move_right  input  1 each  one-cycle move request pulses.
REQ-006 SHALL have ports blk_1..blk_4  output  6 each  falling-piece cell indices, index = y*8 + x.
REQ-007 SHALL have port fallenBlocks  output  8x[7:0], rows 0..7  settled cells; cell (x,y) is fallenBlocks[y][7-x].
REQ-008 SHALL have port gameState  output  1  1 while a game runs (SPAWN/FALL/LOCK/CLEAR), else 0.
REQ-009 SHALL have port score  output  8  count of cleared rows.
REQ-010 SHALL have port busy  output  1  high in LOCK and CLEAR.

Function
REQ-011 Piece SHALL be a 2x2 square; spawn cells 3, 4, 11, 12 (blk_1..blk_4 in that order).
REQ-012 States SHALL be IDLE, SPAWN, FALL, LOCK, CLEAR, OVER.
REQ-013 Gravity counter SHALL run only in FALL, count 0..TICK_DIV-1, raise an internal tick on TICK_DIV-1, wrap to 0, and clear on FALL entry.
REQ-014 move_left, move_right, tick SHALL each set a pending flag; flags persist until serviced, are cleared on entry to IDLE/OVER/SPAWN, and a flag set while already set is absorbed.
REQ-015 In FALL, at most one pending request SHALL be serviced per cycle; priority down (tick) > left > right; unserviced flags stay pending.
REQ-016 A move SHALL be legal only if all four target cells lie within x 0..7, y 0..7 and none is set in fallenBlocks.
REQ-017 A legal move SHALL update blk_1..blk_4 on the edge that services it (one-cycle latency); an illegal left/right SHALL be dropped with no state change.
REQ-018 An illegal down move SHALL transition FALL -> LOCK.
REQ-019 LOCK SHALL OR the four piece cells into fallenBlocks in one cycle, then go to CLEAR with row pointer 7.
REQ-020 CLEAR SHALL test one row per cycle; full row (8'hFF): rows above shift down one, row 0 becomes 0, score increments (saturating at 255), same row re-tested; otherwise pointer decrements; after row 0 is tested non-full, go to SPAWN.
REQ-021 SPAWN SHALL take one cycle: any spawn cell occupied -> OVER (piece positions unchanged); else load spawn cells and go to FALL.
REQ-022 IDLE/OVER SHALL hold all outputs; start SHALL clear fallenBlocks and score and go to SPAWN; start in other states SHALL be ignored.
REQ-023 move requests in IDLE/OVER SHALL be ignored.

Reset
REQ-024 Reset SHALL, at any state including mid-CLEAR, force IDLE, fallenBlocks all 0, score 0, blk_1..blk_4 = 3, 4, 11, 12, gameState 0, busy 0, pending flags and gravity counter 0.
REQ-025 Reset SHALL take priority over start and all requests in the same cycle.

Configuration
REQ-026 With macro TETRIS_HARD_DROP_EN defined, SHALL add input hard_drop (1 bit pulse, pending flag, priority above tick) that moves the piece down one row per cycle until an illegal down, then enters LOCK; left/right stay pending meanwhile.
REQ-027 Without TETRIS_HARD_DROP_EN, port hard_drop and its logic SHALL be absent and behaviour SHALL match REQ-011..REQ-025 exactly.

Verification (TICK_DIV=4)
REQ-028 reset, start -> SPAWN one cycle, FALL with blk = 3,4,11,12, gameState=1; first down after 4 FALL cycles -> blk = 11,12,19,20.
REQ-029 move_left and tick in same FALL cycle -> down serviced that edge, left next edge: blk 3,4,11,12 -> 11,12,19,20 -> 10,11,18,19.
REQ-030 Piece at x=0 (blk 0,1,8,9) plus move_left -> blk unchanged, flag cleared; 3 further move_right -> blk 3,4,11,12.
REQ-031 fallenBlocks rows 6,7 = 8'hFC, piece dropped at x=6..7 (blk 54,55,62,63) -> LOCK, CLEAR removes both rows, fallenBlocks all 0, score=2, busy high throughout LOCK/CLEAR, return to FALL with spawn cells.
REQ-032 fallenBlocks[1] = 8'h18 at SPAWN -> OVER, gameState=0, move pulses ignored; start -> board cleared, score 0, FALL.
REQ-033 reset asserted during CLEAR -> next cycle IDLE with every output at REQ-024 values; with TETRIS_HARD_DROP_EN, hard_drop on empty board from spawn -> blk 51,52,59,60 after 6 cycles, then LOCK.
